mem_stage_mc: RTL and testbench
===============================

Name: mem_stage_mc

Overview:
- Parametrised, multi-cycle successor to the processor's memory stage; sits between the EX/MEM pipeline register and write-back.
- Owns the data memory array and supports byte, half and word accesses with sign or zero extension.
- Inserts a configurable number of wait states per memory access.
- Uses valid/ready handshakes on both sides and a registered MEM/WB output, replacing the purely combinational single-cycle path.

Parameters:
- DEPTH, 1024, data memory size in 32-bit words; power of two.
- ADDR_W, 32, byte-address width of in_addr.
- WAIT_STATES, 2, extra cycles per load/store; 0 allowed.
- RD_W, 3, destination register index width.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  EX/MEM bundle valid
- in_ready  out  1  stage can accept the bundle this cycle
- in_mr  in  1  memory read (load)
- in_mw  in  1  memory write (store)
- in_size  in  2  00 byte, 01 half, 10 word, 11 reserved (treated as word)
- in_signed  in  1  sign-extend load result
- in_addr  in  ADDR_W  byte address (loads/stores) or ALU result
- in_wdata  in  32  store data / pass-through data
- in_wb_en  in  1  register write-back enable
- in_rd  in  RD_W  destination register
- out_valid  out  1  MEM/WB bundle valid
- out_ready  in  1  write-back accepts the bundle
- out_data  out  32  load result or pass-through data
- out_wb_en  out  1  write-back enable
- out_rd  out  RD_W  destination register
- stall  out  1  in_valid & ~in_ready; drives upstream freeze

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; out_valid, out_wb_en, out_data and out_rd = 0; wait counter = 0.
  - Memory contents are not reset.
- Accept: the bundle is captured on an edge where in_valid & in_ready.
- in_ready = (state==IDLE) | (state==RESP & out_ready).
- FSM states: IDLE, WAIT, RESP.
- Accepting a memory op (in_mr | in_mw):
  - WAIT_STATES>0: go to WAIT, counter=WAIT_STATES-1.
  - WAIT_STATES=0: perform the access in the same edge and go to RESP.
- Accepting a non-memory op: go to RESP directly.
  - out_data=in_wdata; in_addr ignored; no memory side effect.
- WAIT: counter decrements each cycle. On counter==0 the access is performed and the FSM moves to RESP.
- Latency: a memory op accepted at edge N gives out_valid=1 after edge N+1+WAIT_STATES. A pass-through op gives out_valid=1 after edge N+1.
- Access addressing:
  - word index = in_addr[log2(DEPTH)+1:2]; upper address bits ignored (wrap-around).
  - Byte lane = in_addr[1:0]; half lane = in_addr[1].
- Store:
  - Writes only the selected byte lanes.
  - out_data=in_wdata; out_wb_en passes through unchanged.
- Load:
  - Selected lane is right-justified.
  - Sign-extended if in_signed=1, else zero-extended.
- in_mr & in_mw both set: treated as a load; no write occurs.
- RESP:
  - out_valid=1; outputs are held stable until out_ready.
  - out_ready=1 with no new accept: return to IDLE.
  - out_ready=1 with in_valid: accept the new bundle in the same edge (zero-bubble back-to-back).
- Captured fields are registered; later changes on in_* during WAIT have no effect.
- Reset asserted mid-WAIT: the pending store is dropped and no memory write occurs.

Optional Feature:
MEM_STAGE_ALIGN_CHECK_EN
- Defined:
  - Adds output port misalign (1 bit, reset 0), valid with out_valid.
  - Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0.
  - A misaligned access performs no memory read or write, forces out_wb_en=0 and out_data=0, and sets misalign=1.
  - Wait states and latency are unchanged.
- Undefined:
  - No misalign port.
  - Low address bits below the access size are ignored: half uses addr[1], word uses lane 0.

Decomposition:
- Package mem_stage_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the state enum IDLE/WAIT/RESP;
  - the DATA_W=32 constant;
  - the lane-extract/extend function.
- One sub-module, mem_stage_ram: synchronous-write, byte-enable DEPTH×32 array with combinational read.
  - The FSM and control logic stay in mem_stage_mc.

Test Plan:
- Store word 0xDEADBEEF at addr 0x10, then load word from 0x10, WAIT_STATES=2 → load out_valid 3 cycles after accept, out_data=0xDEADBEEF.
- Store byte 0x80 at addr 0x13, then load byte signed and unsigned from 0x13 → 0xFFFFFF80 and 0x00000080; word at 0x10 reads 0x80ADBEEF.
- Pass-through op with in_wdata=0x1234, in_rd=5, wb_en=1 → out_valid after 1 cycle, out_data=0x1234, out_rd=5.
- Hold out_ready=0 for 4 cycles in RESP → outputs stable, in_ready=0, stall=1. Release with a new in_valid → accepted on the same edge, no bubble.
- Assert rst mid-WAIT of a store to 0x20 → after reset out_valid=0, and a load of 0x20 returns the prior value.
- With MEM_STAGE_ALIGN_CHECK_EN, load word at 0x22 → misalign=1, out_wb_en=0, out_data=0. Without it → returns word at 0x20.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg
// Shared definitions for the multi-cycle memory stage (mem_stage_mc):
//   - DATA_W        : data path width (32)
//   - SZ_BYTE/HALF/WORD : in_size encodings (2'b11 behaves as word)
//   - IDLE/WAIT/RESP    : FSM state encoding
//   - lane_extract  : pull a byte/half/word out of a memory word and extend it
//   - store_be / store_data : byte enables and lane-replicated write data
//   - misaligned    : natural-alignment test for half/word accesses
package mem_stage_pkg;

    localparam int DATA_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t WAIT = 2'd1;
    localparam state_t RESP = 2'd2;

    // Select the addressed lane of a memory word and right-justify it.
    // Half accesses only look at lane[1]; word accesses ignore the lane.
    function automatic logic [DATA_W-1:0] lane_extract(
        input logic [DATA_W-1:0] word,
        input logic [1:0]        lane,
        input logic [1:0]        size,
        input logic              sgn
    );
        logic [7:0]        b;
        logic [15:0]       h;
        logic [DATA_W-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            SZ_HALF: r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << lane;
            SZ_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Replicate the low bytes across all lanes so the byte enables alone
    // decide which lanes are written.
    function automatic logic [DATA_W-1:0] store_data(
        input logic [DATA_W-1:0] wdata,
        input logic [1:0]        size
    );
        logic [DATA_W-1:0] d;
        case (size)
            SZ_BYTE: d = {4{wdata[7:0]}};
            SZ_HALF: d = {2{wdata[15:0]}};
            default: d = wdata;
        endcase
        return d;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lane
    );
        logic m;
        case (size)
            SZ_BYTE: m = 1'b0;
            SZ_HALF: m = lane[0];
            default: m = |lane;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/mem_stage_ram.sv
// mem_stage_ram
// DEPTH x 32 data memory: synchronous byte-enabled write, combinational read.
// Contents are never reset.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable
//   be    : per-byte write enables (bit i -> bits [8i+7:8i])
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : combinational read data at addr
module mem_stage_ram
    import mem_stage_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [IDX_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    // One byte-wide array per lane keeps the byte enables trivial.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:DEPTH-1];

            always_ff @(posedge clk) begin
                if (we && be[gi]) begin
                    lane_mem[addr] <= wdata[8*gi +: 8];
                end
            end

            assign rdata[8*gi +: 8] = lane_mem[addr];
        end
    endgenerate

endmodule

// File: rtl/mem_stage_mc.sv
// mem_stage_mc
// Multi-cycle memory stage between the EX/MEM register and write-back.
// Accepts one bundle at a time (valid/ready), spends WAIT_STATES extra
// cycles on loads/stores, and presents a registered MEM/WB bundle that is
// held until out_ready.
// Optional build macro MEM_STAGE_ALIGN_CHECK_EN adds the misalign output and
// suppresses misaligned half/word accesses.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   in_valid/in_ready        : upstream handshake
//   in_mr, in_mw             : load / store request (both set = load)
//   in_size, in_signed       : access size and load extension
//   in_addr, in_wdata        : byte address / store or pass-through data
//   in_wb_en, in_rd          : write-back control
//   out_valid/out_ready      : downstream handshake
//   out_data, out_wb_en, out_rd : registered MEM/WB bundle
//   misalign                 : (optional) access was misaligned
//   stall                    : in_valid & ~in_ready
module mem_stage_mc
    import mem_stage_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 2,
    parameter int RD_W        = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mr,
    input  logic              in_mw,
    input  logic [1:0]        in_size,
    input  logic              in_signed,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_wb_en,
    input  logic [RD_W-1:0]   in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wb_en,
    output logic [RD_W-1:0]   out_rd,
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    output logic              misalign,
`endif
    output logic              stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = IDX_W + 2;          // address bits that matter
    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
    localparam logic ZERO_WAIT = (WAIT_STATES == 0);

    // State and captured bundle
    state_t            state_reg, state_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              cap_mr_reg, cap_mw_reg, cap_signed_reg, cap_wb_en_reg;
    logic [1:0]        cap_size_reg;
    logic [AW-1:0]     cap_addr_reg;
    logic [DATA_W-1:0] cap_wdata_reg;
    logic [RD_W-1:0]   cap_rd_reg;

    // Registered output bundle
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic              out_wb_en_reg, out_wb_en_next;
    logic [RD_W-1:0]   out_rd_reg, out_rd_next;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic              misalign_reg, misalign_next;
`endif

    logic cap_load, out_load;
    logic accept;

    // Access operands: from the captured bundle while waiting, otherwise
    // straight from the inputs (pass-through, or zero-wait access).
    logic              use_cap;
    logic              acc_mr, acc_mw, acc_signed, acc_wb_en, acc_mem, acc_bad;
    logic [1:0]        acc_size, acc_lane;
    logic [AW-1:0]     acc_addr;
    logic [DATA_W-1:0] acc_wdata, acc_data, ram_rdata, load_val;
    logic              acc_wb, do_access, ram_we;

    assign in_ready  = (state_reg == IDLE) | ((state_reg == RESP) & out_ready);
    assign accept    = in_valid & in_ready;
    assign stall     = in_valid & ~in_ready;
    assign out_valid = (state_reg == RESP);

    assign use_cap    = (state_reg == WAIT);
    assign acc_mr     = use_cap ? cap_mr_reg     : in_mr;
    assign acc_mw     = use_cap ? cap_mw_reg     : in_mw;
    assign acc_size   = use_cap ? cap_size_reg   : in_size;
    assign acc_signed = use_cap ? cap_signed_reg : in_signed;
    assign acc_addr   = use_cap ? cap_addr_reg   : in_addr[AW-1:0];
    assign acc_wdata  = use_cap ? cap_wdata_reg  : in_wdata;
    assign acc_wb_en  = use_cap ? cap_wb_en_reg  : in_wb_en;
    assign acc_mem    = acc_mr | acc_mw;
    assign acc_lane   = acc_addr[1:0];

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign acc_bad = acc_mem & misaligned(acc_size, acc_lane);
`else
    assign acc_bad = 1'b0;
`endif

    // The access happens on the last WAIT edge, or on the accept edge when
    // there are no wait states.
    assign do_access = ((state_reg == WAIT) && (cnt_reg == '0)) |
                       (accept & (in_mr | in_mw) & ZERO_WAIT);

    // Load wins when both mr and mw are set. Gating with rst keeps a store
    // from landing while reset is held (the RAM itself has no reset).
    assign ram_we = do_access & acc_mw & ~acc_mr & ~acc_bad & rst;

    mem_stage_ram #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .be    (store_be(acc_size, acc_lane)),
        .addr  (acc_addr[AW-1:2]),
        .wdata (store_data(acc_wdata, acc_size)),
        .rdata (ram_rdata)
    );

    assign load_val = lane_extract(ram_rdata, acc_lane, acc_size, acc_signed);
    assign acc_data = acc_bad ? '0 : (acc_mr ? load_val : acc_wdata);
    assign acc_wb   = acc_bad ? 1'b0 : acc_wb_en;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        cap_load       = 1'b0;
        out_load       = 1'b0;
        out_data_next  = out_data_reg;
        out_wb_en_next = out_wb_en_reg;
        out_rd_next    = out_rd_reg;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        misalign_next  = misalign_reg;
`endif
        case (state_reg)
            IDLE: ;
            WAIT: begin
                if (cnt_reg == '0) begin
                    state_next     = RESP;
                    out_load       = 1'b1;
                    out_data_next  = acc_data;
                    out_wb_en_next = acc_wb;
                    out_rd_next    = cap_rd_reg;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                    misalign_next  = acc_bad;
`endif
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            RESP: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // A new bundle overrides the RESP->IDLE return (zero-bubble).
        if (accept) begin
            cap_load = 1'b1;
            if ((in_mr | in_mw) && !ZERO_WAIT) begin
                state_next = WAIT;
                cnt_next   = CNT_INIT;
            end else begin
                state_next     = RESP;
                out_load       = 1'b1;
                out_data_next  = acc_data;
                out_wb_en_next = acc_wb;
                out_rd_next    = in_rd;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                misalign_next  = acc_bad;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            cap_mr_reg     <= 1'b0;
            cap_mw_reg     <= 1'b0;
            cap_size_reg   <= SZ_BYTE;
            cap_signed_reg <= 1'b0;
            cap_addr_reg   <= '0;
            cap_wdata_reg  <= '0;
            cap_wb_en_reg  <= 1'b0;
            cap_rd_reg     <= '0;
            out_data_reg   <= '0;
            out_wb_en_reg  <= 1'b0;
            out_rd_reg     <= '0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
            misalign_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (cap_load) begin
                cap_mr_reg     <= in_mr;
                cap_mw_reg     <= in_mw;
                cap_size_reg   <= in_size;
                cap_signed_reg <= in_signed;
                cap_addr_reg   <= in_addr[AW-1:0];
                cap_wdata_reg  <= in_wdata;
                cap_wb_en_reg  <= in_wb_en;
                cap_rd_reg     <= in_rd;
            end
            if (out_load) begin
                out_data_reg  <= out_data_next;
                out_wb_en_reg <= out_wb_en_next;
                out_rd_reg    <= out_rd_next;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
                misalign_reg  <= misalign_next;
`endif
            end
        end
    end

    assign out_data  = out_data_reg;
    assign out_wb_en = out_wb_en_reg;
    assign out_rd    = out_rd_reg;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign  = misalign_reg;
`endif

    // Address bits above the memory size wrap around and are not used.
    generate
        if (ADDR_W > AW) begin : g_addr_hi
            logic unused_addr_hi;
            assign unused_addr_hi = ^in_addr[ADDR_W-1:AW];
        end
    endgenerate

endmodule

// File: tb/tb_mem_stage_mc.sv
// tb_mem_stage_mc
// Randomized + directed bench for mem_stage_mc against a byte-array model.
module tb_mem_stage_mc;

    localparam int WS    = 2;
    localparam int DEPTH = 1024;
    localparam int BYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_mr, in_mw, in_signed, in_wb_en;
    logic [1:0]  in_size;
    logic [31:0] in_addr, in_wdata;
    logic [2:0]  in_rd;
    logic        out_valid, out_ready, out_wb_en, stall;
    logic [31:0] out_data;
    logic [2:0]  out_rd;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    mem_stage_mc #(
        .DEPTH       (DEPTH),
        .ADDR_W      (32),
        .WAIT_STATES (WS),
        .RD_W        (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mr     (in_mr),
        .in_mw     (in_mw),
        .in_size   (in_size),
        .in_signed (in_signed),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .in_wb_en  (in_wb_en),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_wb_en (out_wb_en),
        .out_rd    (out_rd),
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        .misalign  (misalign),
`endif
        .stall     (stall)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [0:BYTES-1];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model (byte-addressed, little-endian) -----
    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    endfunction

    function automatic int eff_base(input logic [31:0] addr, input logic [1:0] size);
        int a;
        a = int'(addr % BYTES);
        a = a - (a % nbytes(size));
        return a;
    endfunction

    function automatic bit is_mis(input logic [31:0] addr, input logic [1:0] size);
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size, input bit sgn);
        longint v;
        int     n;
        int     b;
        n = nbytes(size);
        b = eff_base(addr, size);
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[b + i]) << (8 * i);
        if (sgn && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    task automatic model_store(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wdata);
        int n;
        int b;
        n = nbytes(size);
        b = eff_base(addr, size);
        for (int i = 0; i < n; i++) ref_mem[b + i] = 8'((wdata >> (8 * i)) & 32'hFF);
    endtask

    task automatic drive(input bit mr, input bit mw, input logic [1:0] size, input bit sgn,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input bit wb_en, input logic [2:0] rd);
        in_valid  = 1'b1;
        in_mr     = mr;
        in_mw     = mw;
        in_size   = size;
        in_signed = sgn;
        in_addr   = addr;
        in_wdata  = wdata;
        in_wb_en  = wb_en;
        in_rd     = rd;
    endtask

    task automatic scramble();
        in_valid  = 1'b0;
        in_mr     = 1'($urandom);
        in_mw     = 1'($urandom);
        in_size   = 2'($urandom);
        in_signed = 1'($urandom);
        in_addr   = $urandom;
        in_wdata  = $urandom;
        in_wb_en  = 1'($urandom);
        in_rd     = 3'($urandom);
    endtask

    // One complete transaction from IDLE; 'hold' cycles of out_ready=0 in RESP.
    task automatic run_op(input bit mr, input bit mw, input logic [1:0] size, input bit sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input bit wb_en, input logic [2:0] rd, input int hold,
                          output logic [31:0] got);
        logic [31:0] exp_data;
        bit          exp_wb;
        bit          mem_op;
        bit          bad;
        int          lat;
        mem_op = mr | mw;
        bad    = 1'b0;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        bad    = mem_op && is_mis(addr, size);
`endif
        exp_wb = wb_en;
        if (bad) begin
            exp_data = 32'd0;
            exp_wb   = 1'b0;
        end else if (mr) begin
            exp_data = model_load(addr, size, sgn);
        end else begin
            exp_data = wdata;
            if (mw) model_store(addr, size, wdata);
        end

        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        drive(mr, mw, size, sgn, addr, wdata, wb_en, rd);
        @(posedge clk);
        @(negedge clk);
        scramble();
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), mem_op ? 32'(WS + 1) : 32'd1);
        got = out_data;
        if (hold > 0) begin
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", out_data, got);
            end
            out_ready = 1'b1;
        end
        check("data", out_data, exp_data);
        check("wb_en", 32'(out_wb_en), 32'(exp_wb));
        check("rd", 32'(out_rd), 32'(rd));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        check("misalign", 32'(misalign), 32'(bad));
`endif
        $display("txn mr=%0d mw=%0d size=%0d sgn=%0d addr=0x%08h wdata=0x%08h -> data=0x%08h exp=0x%08h lat=%0d",
                 mr, mw, size, sgn, addr, wdata, out_data, exp_data, lat);
    endtask

    initial begin
        logic [31:0] got;
        logic [31:0] a;
        logic [1:0]  op;

        rst       = 1'b0;
        out_ready = 1'b1;
        scramble();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_wb_en", 32'(out_wb_en), 32'd0);
        check("rst_out_rd", 32'(out_rd), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_stall", 32'(stall), 32'd0);
        rst = 1'b1;

        // Initialise the exercised region (0x00..0x3F)
        for (int i = 0; i < 16; i++) run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 1'b0, 3'd0, 0, got);

        // Word store / load
        run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 3'd1, 0, got);
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 3'd2, 0, got);
        check("plan_ld_word", got, 32'hDEADBEEF);

        // Byte store, signed/unsigned byte loads, word readback
        run_op(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h80, 1'b0, 3'd0, 0, got);
        run_op(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 1'b1, 3'd3, 0, got);
        check("plan_ld_byte_s", got, 32'hFFFFFF80);
        run_op(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b1, 3'd4, 0, got);
        check("plan_ld_byte_u", got, 32'h00000080);
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 3'd4, 0, got);
        check("plan_ld_word2", got, 32'h80ADBEEF);

        // Pass-through
        run_op(1'b0, 1'b0, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h1234, 1'b1, 3'd5, 0, got);
        check("plan_pass", got, 32'h1234);

        // Back-pressure then zero-bubble accept
        @(negedge clk);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h1234, 1'b1, 3'd5);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h4, 32'hABCD, 1'b0, 3'd3);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_stall", 32'(stall), 32'd1);
            check("bp_data", out_data, 32'h1234);
            check("bp_rd", 32'(out_rd), 32'd5);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_stall", 32'(stall), 32'd0);
        @(posedge clk);
        @(negedge clk);
        scramble();
        check("b2b_valid", 32'(out_valid), 32'd1);
        check("b2b_data", out_data, 32'hABCD);
        check("b2b_rd", 32'(out_rd), 32'd3);
        check("b2b_wb_en", 32'(out_wb_en), 32'd0);
        $display("txn back-to-back pass-through data=0x%08h rd=%0d", out_data, out_rd);

        // Reset in the middle of a store's wait states
        run_op(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADF00D, 1'b0, 3'd0, 0, got);
        @(negedge clk);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 32'h20, 32'h55AA55AA, 1'b0, 3'd0);
        @(posedge clk);
        @(negedge clk);
        scramble();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midwait_rst_valid", 32'(out_valid), 32'd0);
        check("midwait_rst_ready", 32'(in_ready), 32'd1);
        $display("txn reset during store wait states");
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, 3'd6, 0, got);
        check("midwait_ld", got, 32'h0BADF00D);

        // Unaligned word load
        run_op(1'b1, 1'b0, 2'd2, 1'b0, 32'h22, 32'h0, 1'b1, 3'd7, 0, got);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        check("unaligned_ld", got, 32'h0);
`else
        check("unaligned_ld", got, 32'h0BADF00D);
`endif

        // Randomized traffic with address wrap-around and back-pressure
        for (int t = 0; t < 60; t++) begin
            a  = ($urandom & 32'hFFFFF000) | 32'($urandom_range(0, 63));
            op = 2'($urandom_range(0, 3));
            run_op(op[0], op[1], 2'($urandom_range(0, 3)), 1'($urandom), a, $urandom,
                   1'($urandom), 3'($urandom), $urandom_range(0, 2), got);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
